// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: programmable AXI-stream packet source.
//
// Emits cfg_pkt_count packets (0 = unbounded) of cfg_pkt_len bytes, separated by
// cfg_gap_cycles idle cycles, all tagged with cfg_flow_class. Configuration is latched
// on the start pulse. Each beat carries {class, beat index, packet sequence number} in
// its low bits so a downstream monitor can detect drops, duplicates and reordering.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, stop         one-cycle control pulses
//   cfg_*               run configuration (sampled on start only)
//   m_axis_*            AXI-stream master (tdata, tkeep, tvalid, tready, tlast)
//   m_flow_class        class tag of the presented beat (0 when tvalid is low)
//   busy, done          run in progress / run finished (held until next start)
//   sent_frame_count    accepted beats in the current run
//   sent_pkt_count      accepted packets (tlast handshakes) in the current run
module axis_traffic_gen #(
  parameter int unsigned AXIS_DATA_WIDTH = 256,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned GAP_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [15:0]                cfg_pkt_len,
  input  logic [GAP_WIDTH-1:0]       cfg_gap_cycles,
  input  logic [31:0]                cfg_pkt_count,
  input  logic [4:0]                 cfg_flow_class,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [4:0]                 m_flow_class,
  output logic                       busy,
  output logic                       done,
  output logic [47:0]                sent_frame_count,
  output logic [31:0]                sent_pkt_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]          count_q, count_d;
  logic [4:0]           class_q, class_d;
  logic [31:0]          seq_q, seq_d;
  logic [15:0]          beat_q, beat_d;
  logic [47:0]          frame_q, frame_d;
  logic [31:0]          pkt_q, pkt_d;
  logic                 stop_pend_q, stop_pend_d;

  // len_q is never 0 once latched, so (len-1)/KEEP is the index of the final beat.
  logic [15:0]                last_beat;
  logic [15:0]                last_bytes;
  logic [AXIS_KEEP_WIDTH-1:0] last_keep;
  logic                       is_last;
  logic                       hs;
  logic                       count_hit;

  assign last_beat  = (len_q - 16'd1) / 16'(AXIS_KEEP_WIDTH);
  assign last_bytes = len_q - 16'(last_beat * 16'(AXIS_KEEP_WIDTH));
  assign is_last    = (beat_q == last_beat);
  assign hs         = m_axis_tvalid && m_axis_tready;
  assign count_hit  = (count_q != 32'd0) && ((pkt_q + 32'd1) == count_q);

  always_comb begin
    last_keep = '0;
    for (int unsigned i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      last_keep[i] = (i < {16'd0, last_bytes});
    end
  end

  assign m_axis_tvalid    = (state_q == StSend);
  assign busy             = (state_q == StSend) || (state_q == StGap);
  assign done             = (state_q == StDone);
  assign sent_frame_count = frame_q;
  assign sent_pkt_count   = pkt_q;

  // Payload fields are gated by tvalid so every output reads 0 outside SEND.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_flow_class  = 5'd0;
    if (m_axis_tvalid) begin
      m_axis_tdata[31:0]  = seq_q;
      m_axis_tdata[47:32] = beat_q;
      m_axis_tdata[52:48] = class_q;
      m_axis_tkeep        = is_last ? last_keep : '1;
      m_axis_tlast        = is_last;
      m_flow_class        = class_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    count_d     = count_q;
    class_d     = class_q;
    seq_d       = seq_q;
    beat_d      = beat_q;
    frame_d     = frame_q;
    pkt_d       = pkt_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StSend;
          len_d       = (cfg_pkt_len == 16'd0) ? 16'd1 : cfg_pkt_len;
          gap_d       = cfg_gap_cycles;
          count_d     = cfg_pkt_count;
          class_d     = cfg_flow_class;
          seq_d       = 32'd0;
          beat_d      = 16'd0;
          frame_d     = 48'd0;
          pkt_d       = 32'd0;
          stop_pend_d = 1'b0;
        end
      end
      StSend: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (hs) begin
          frame_d = frame_q + 48'd1;
          if (is_last) begin
            pkt_d  = pkt_q + 32'd1;
            seq_d  = seq_q + 32'd1;
            beat_d = 16'd0;
            // A stop arriving with the tlast handshake still ends the run here.
            if (count_hit || stop_pend_q || stop) begin
              state_d = StDone;
            end else if (gap_q != '0) begin
              state_d   = StGap;
              gap_cnt_d = gap_q;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (stop || stop_pend_q) begin
          state_d = StDone;
        end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= 16'd1;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      count_q     <= 32'd0;
      class_q     <= 5'd0;
      seq_q       <= 32'd0;
      beat_q      <= 16'd0;
      frame_q     <= 48'd0;
      pkt_q       <= 32'd0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      count_q     <= count_d;
      class_q     <= class_d;
      seq_q       <= seq_d;
      beat_q      <= beat_d;
      frame_q     <= frame_d;
      pkt_q       <= pkt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: randomized runs checked against a packet-level model.
module tb_axis_traffic_gen;

  localparam int DW = 256;
  localparam int K  = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [K-1:0]  keep;
    logic          last;
    logic [4:0]    cls;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   cfg_pkt_len = 16'd0;
  logic [15:0]   cfg_gap_cycles = 16'd0;
  logic [31:0]   cfg_pkt_count = 32'd0;
  logic [4:0]    cfg_flow_class = 5'd0;
  logic [DW-1:0] m_axis_tdata;
  logic [K-1:0]  m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [4:0]    m_flow_class;
  logic          busy;
  logic          done;
  logic [47:0]   sent_frame_count;
  logic [31:0]   sent_pkt_count;

  axis_traffic_gen #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(K),
    .GAP_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .cfg_pkt_len(cfg_pkt_len),
    .cfg_gap_cycles(cfg_gap_cycles),
    .cfg_pkt_count(cfg_pkt_count),
    .cfg_flow_class(cfg_flow_class),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_flow_class(m_flow_class),
    .busy(busy),
    .done(done),
    .sent_frame_count(sent_frame_count),
    .sent_pkt_count(sent_pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  beat_t got_q[$];
  beat_t exp_q[$];
  bit    vq[$];
  bit    expv_q[$];

  logic  s_vld, s_done, s_busy;
  beat_t s_beat;

  // Outputs are read on the falling edge; new inputs then apply to the next rising edge.
  task automatic sample();
    @(negedge clk);
    s_vld  = m_axis_tvalid;
    s_done = done;
    s_busy = busy;
    s_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_flow_class};
  endtask

  task automatic drive(input logic rdy, input logic st, input logic sp);
    m_axis_tready = rdy;
    start = st;
    stop = sp;
    if (s_vld && rdy) got_q.push_back(s_beat);
  endtask

  task automatic configure(input int len, input int gap, input int cnt, input int cls);
    cfg_pkt_len    = 16'(len);
    cfg_gap_cycles = 16'(gap);
    cfg_pkt_count  = 32'(cnt);
    cfg_flow_class = 5'(cls);
  endtask

  task automatic kick();
    got_q.delete();
    vq.delete();
    sample();
    drive(1'b1, 1'b1, 1'b0);
  endtask

  // Reference: the beats of npkts packets, plus the tvalid pattern seen with tready=1
  // (B high cycles per packet, gap low cycles between packets, then the done cycle).
  function automatic void build(input int len, input int cls, input int npkts, input int gap);
    int l;
    int nb;
    beat_t e;
    l = (len == 0) ? 1 : len;
    nb = (l + K - 1) / K;
    exp_q.delete();
    expv_q.delete();
    for (int p = 0; p < npkts; p++) begin
      for (int b = 0; b < nb; b++) begin
        e = '0;
        e.data[31:0]  = 32'(p);
        e.data[47:32] = 16'(b);
        e.data[52:48] = 5'(cls);
        e.cls         = 5'(cls);
        if (b == nb - 1) begin
          e.keep = K'((64'd1 << (l - (nb - 1) * K)) - 64'd1);
          e.last = 1'b1;
        end else begin
          e.keep = '1;
          e.last = 1'b0;
        end
        exp_q.push_back(e);
        expv_q.push_back(1'b1);
      end
      if (p != npkts - 1) for (int g = 0; g < gap; g++) expv_q.push_back(1'b0);
    end
    expv_q.push_back(1'b0);
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int vq_diff();
    int n;
    n = (vq.size() < expv_q.size()) ? vq.size() : expv_q.size();
    for (int i = 0; i < n; i++) if (vq[i] != expv_q[i]) return i;
    if (vq.size() != expv_q.size()) return n;
    return -1;
  endfunction

  function automatic string show(input bit from_got, input int i);
    beat_t b;
    if (from_got ? (i >= got_q.size()) : (i >= exp_q.size())) return "none";
    b = from_got ? got_q[i] : exp_q[i];
    return $sformatf("seq=%0d beat=%0d dcls=%0d cls=%0d keep=%h last=%b rest=%0d",
                     b.data[31:0], b.data[47:32], b.data[52:48], b.cls, b.keep, b.last,
                     (b.data >> 53) != 0);
  endfunction

  task automatic run_until_done(input int budget, output bit fin);
    fin = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample();
      vq.push_back(s_vld);
      if (s_done) begin
        fin = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        break;
      end
      drive(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) sample();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b required 0 0 0",
               m_axis_tvalid, busy, done);
    end
    n_checks++;
    if (sent_frame_count !== 48'd0 || sent_pkt_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: frames=%0d pkts=%0d required 0 0",
               sent_frame_count, sent_pkt_count);
    end
    n_checks++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0 ||
        m_flow_class !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_payload: tdata=%h tkeep=%h tlast=%b class=%0d required all 0",
               m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_flow_class);
    end
    rst = 1'b0;
    configure(20, 0, 0, 3);
    sample();
    drive(1'b1, 1'b0, 1'b1);
    repeat (2) sample();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_stop: valid=%b busy=%b done=%b required 0 0 0",
               m_axis_tvalid, busy, done);
    end
  endtask

  // Fixed-ready run: checks beats, exact tvalid timing and final counters.
  task automatic test_timed(input string name, input int len, input int gap, input int cnt,
                            input int cls);
    bit fin;
    int d;
    configure(len, gap, cnt, cls);
    build(len, cls, cnt, gap);
    kick();
    run_until_done(400, fin);
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s_done: done never seen within 400 cycles, required done=1", name);
    end
    d = vq_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL %s_valid_timing: cycle %0d after start tvalid=%0d required %0d",
               name, d + 1, (d < vq.size()) ? int'(vq[d]) : -1,
               (d < expv_q.size()) ? int'(expv_q[d]) : -1);
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL %s_beats: beat %0d got [%s] required [%s]", name, d, show(1, d), show(0, d));
    end
    n_checks++;
    if (sent_frame_count !== 48'(exp_q.size()) || sent_pkt_count !== 32'(cnt) ||
        done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_counts: frames=%0d pkts=%0d done=%b busy=%b required %0d %0d 1 0",
               name, sent_frame_count, sent_pkt_count, done, busy, exp_q.size(), cnt);
    end
  endtask

  task automatic test_backpressure(input int len, input int gap, input int cnt, input int cls);
    bit    fin;
    bit    prev_stall;
    beat_t prev_beat;
    logic  rdy;
    int    d;
    configure(len, gap, cnt, cls);
    build(len, cls, cnt, gap);
    kick();
    fin = 1'b0;
    prev_stall = 1'b0;
    prev_beat = '0;
    for (int i = 0; i < 3000; i++) begin
      sample();
      if (prev_stall) begin
        n_checks++;
        if (s_vld !== 1'b1 || s_beat !== prev_beat) begin
          n_fail++;
          $display("FAIL bp_stable: cycle %0d valid=%b [%s] required held beat seq=%0d beat=%0d",
                   i, s_vld, $sformatf("seq=%0d beat=%0d keep=%h last=%b", s_beat.data[31:0],
                   s_beat.data[47:32], s_beat.keep, s_beat.last),
                   prev_beat.data[31:0], prev_beat.data[47:32]);
        end
      end
      if (s_done) begin
        fin = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        break;
      end
      rdy = 1'($urandom_range(0, 1));
      drive(rdy, 1'b0, 1'b0);
      prev_stall = s_vld && !rdy;
      prev_beat = s_beat;
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL bp_done: done never seen within 3000 cycles, required done=1");
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL bp_beats: len=%0d beat %0d got [%s] required [%s]",
               len, d, show(1, d), show(0, d));
    end
    n_checks++;
    if (sent_frame_count !== 48'(exp_q.size()) || sent_pkt_count !== 32'(cnt)) begin
      n_fail++;
      $display("FAIL bp_counts: frames=%0d pkts=%0d required %0d %0d",
               sent_frame_count, sent_pkt_count, exp_q.size(), cnt);
    end
  endtask

  task automatic test_stop_send();
    bit sent;
    bit fin;
    bit sp;
    int d;
    configure(96, 0, 0, 1);
    build(96, 1, 6, 0);
    kick();
    sent = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sample();
      if (s_done) begin
        fin = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        break;
      end
      sp = !sent && s_vld && s_beat.data[31:0] == 32'd5 && s_beat.data[47:32] == 16'd1;
      if (sp) sent = 1'b1;
      drive(1'b1, 1'b0, sp);
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL stop_send_done: done never seen within 200 cycles, required done=1");
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL stop_send_beats: beat %0d got [%s] required [%s]", d, show(1, d), show(0, d));
    end
    n_checks++;
    if (sent_pkt_count !== 32'd6 || sent_frame_count !== 48'd18) begin
      n_fail++;
      $display("FAIL stop_send_counts: pkts=%0d frames=%0d required 6 18",
               sent_pkt_count, sent_frame_count);
    end
  endtask

  task automatic test_stop_gap();
    int gap_seen;
    int stop_at;
    int done_at;
    int late_valid;
    configure(32, 5, 0, 2);
    kick();
    gap_seen = 0;
    stop_at = -1;
    done_at = -1;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (s_done) begin
        done_at = i;
        drive(1'b1, 1'b0, 1'b0);
        break;
      end
      if (got_q.size() >= 1 && !s_vld && s_busy) gap_seen++;
      if (gap_seen == 2 && stop_at < 0) begin
        stop_at = i;
        drive(1'b1, 1'b0, 1'b1);
      end else begin
        drive(1'b1, 1'b0, 1'b0);
      end
    end
    n_checks++;
    if (stop_at < 0 || done_at != stop_at + 1) begin
      n_fail++;
      $display("FAIL stop_gap_latency: stop at cycle %0d, done at cycle %0d, required %0d",
               stop_at, done_at, stop_at + 1);
    end
    late_valid = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (s_vld) late_valid++;
      drive(1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (late_valid != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_gap_quiet: tvalid cycles=%0d done=%b required 0 1", late_valid, done);
    end
    n_checks++;
    if (sent_pkt_count !== 32'd1 || sent_frame_count !== 48'd1) begin
      n_fail++;
      $display("FAIL stop_gap_counts: pkts=%0d frames=%0d required 1 1",
               sent_pkt_count, sent_frame_count);
    end
  endtask

  task automatic test_rst_mid();
    bit fin;
    int d;
    configure(200, 0, 0, 6);
    kick();
    repeat (3) begin
      sample();
      drive(1'b1, 1'b0, 1'b0);
    end
    sample();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    sample();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        sent_frame_count !== 48'd0 || sent_pkt_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b busy=%b done=%b frames=%0d pkts=%0d required 0 0 0 0 0",
               m_axis_tvalid, busy, done, sent_frame_count, sent_pkt_count);
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    configure(40, 1, 2, 6);
    build(40, 6, 2, 1);
    kick();
    run_until_done(100, fin);
    d = first_diff();
    n_checks++;
    if (!fin || d != -1) begin
      n_fail++;
      $display("FAIL rst_restart: done=%b beat %0d got [%s] required [%s]",
               fin, d, show(1, d), show(0, d));
    end
  endtask

  task automatic test_short_busy_start();
    bit fin;
    bit restarted;
    int d;
    configure(0, 2, 3, 4);
    build(0, 4, 3, 2);
    kick();
    fin = 1'b0;
    restarted = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample();
      vq.push_back(s_vld);
      if (s_done) begin
        fin = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        break;
      end
      if (got_q.size() == 1 && !restarted) begin
        restarted = 1'b1;
        configure(100, 0, 9, 7);
        drive(1'b1, 1'b1, 1'b0);
      end else begin
        drive(1'b1, 1'b0, 1'b0);
      end
    end
    d = first_diff();
    n_checks++;
    if (!fin || d != -1) begin
      n_fail++;
      $display("FAIL short_beats: done=%b beat %0d got [%s] required [%s]",
               fin, d, show(1, d), show(0, d));
    end
    d = vq_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL short_timing: cycle %0d tvalid=%0d required %0d", d + 1,
               (d < vq.size()) ? int'(vq[d]) : -1, (d < expv_q.size()) ? int'(expv_q[d]) : -1);
    end
    n_checks++;
    if (sent_pkt_count !== 32'd3 || sent_frame_count !== 48'd3) begin
      n_fail++;
      $display("FAIL short_counts: pkts=%0d frames=%0d required 3 3",
               sent_pkt_count, sent_frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_timed("basic", 100, 0, 2, 3);
    test_timed("gap", 64, 3, 3, 17);
    test_timed("rnd", int'($urandom_range(1, 300)), int'($urandom_range(0, 4)),
               int'($urandom_range(1, 4)), int'($urandom_range(0, 31)));
    test_backpressure(32, 0, 6, 9);
    test_backpressure(int'($urandom_range(1, 300)), int'($urandom_range(0, 2)), 3,
                      int'($urandom_range(0, 31)));
    test_stop_send();
    test_stop_gap();
    test_rst_mid();
    test_short_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "time limit");
  end

endmodule
